// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: holds architectural HI/LO and runs MULT/DIV as
// fixed-latency busy sequences whose results land in HI/LO when busy falls.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_en,
    input  logic [3:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_busy,
    output logic [31:0] out_rdata,
    output logic [31:0] out_hi,
    output logic [31:0] out_lo
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pend_hi;
    logic [31:0]        r_pend_lo;
    logic               r_pend_wr;

    logic               w_accept;
    logic               w_is_mult;
    logic               w_is_div;
    logic               w_start;
    logic               w_commit;

    logic [63:0]        w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_div_signed;
    logic [31:0]        w_abs_a;
    logic [31:0]        w_abs_b;
    logic [31:0]        w_dvd;
    logic [31:0]        w_dvs;
    logic [31:0]        w_uquo;
    logic [31:0]        w_urem;
    logic [31:0]        w_div_quo;
    logic [31:0]        w_div_rem;

    logic [31:0]        w_res_hi;
    logic [31:0]        w_res_lo;
    logic               w_res_wr;

    assign w_accept  = in_en & ~out_busy;
    assign w_is_mult = (in_op == OP_MULT) || (in_op == OP_MULTU);
    assign w_is_div  = (in_op == OP_DIV) || (in_op == OP_DIVU);
    assign w_start   = w_accept & (w_is_mult | w_is_div);

    // Low 64 bits of a 64x64 product of the extended operands is the exact 32x32 product.
    assign w_prod_s = {{32{in_a[31]}}, in_a} * {{32{in_b[31]}}, in_b};
    assign w_prod_u = {32'd0, in_a} * {32'd0, in_b};

    // One unsigned divider on magnitudes serves both DIV and DIVU; the
    // 0x80000000 / -1 case falls out naturally as magnitude 2^31 negated.
    assign w_div_signed = (in_op == OP_DIV);
    assign w_abs_a   = (w_div_signed && in_a[31]) ? (~in_a + 32'd1) : in_a;
    assign w_abs_b   = (w_div_signed && in_b[31]) ? (~in_b + 32'd1) : in_b;
    assign w_dvd     = w_abs_a;
    assign w_dvs     = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
    assign w_uquo    = w_dvd / w_dvs;
    assign w_urem    = w_dvd % w_dvs;
    assign w_div_quo = (w_div_signed && (in_a[31] ^ in_b[31])) ? (~w_uquo + 32'd1) : w_uquo;
    assign w_div_rem = (w_div_signed && in_a[31]) ? (~w_urem + 32'd1) : w_urem;

    always_comb begin
        w_res_hi = '0;
        w_res_lo = '0;
        w_res_wr = 1'b0;
        case (in_op)
            OP_MULT: begin
                {w_res_hi, w_res_lo} = w_prod_s;
                w_res_wr = 1'b1;
            end
            OP_MULTU: begin
                {w_res_hi, w_res_lo} = w_prod_u;
                w_res_wr = 1'b1;
            end
            OP_DIV, OP_DIVU: begin
                // A zero divisor still burns the full latency but leaves HI/LO alone.
                if (in_b != 32'd0) begin
                    w_res_hi = w_div_rem;
                    w_res_lo = w_div_quo;
                    w_res_wr = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_start) w_state_next = S_BUSY;
            S_BUSY: if (r_cnt == CNT_W'(1)) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        out_busy = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_BUSY: begin
                out_busy = 1'b1;
                w_commit = (r_cnt == CNT_W'(1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= w_is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (out_busy && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
        end else if (w_start) begin
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
            r_pend_wr <= w_res_wr;
        end
    end

    // Commit and MTHI/MTLO never coincide: moves are only accepted while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            if (r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (w_accept) begin
            if (in_op == OP_MTHI) r_hi <= in_a;
            if (in_op == OP_MTLO) r_lo <= in_a;
        end
    end

    assign out_rdata = (in_op == OP_MFHI) ? r_hi : r_lo;
    assign out_hi    = r_hi;
    assign out_lo    = r_lo;

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: stimulus pushes expected HI/LO/latency and read
// data into queues, a negedge monitor pops them when busy falls or a read is flagged.
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MTHI  = 4'd5;
    localparam logic [3:0] MTLO  = 4'd6;
    localparam logic [3:0] MFHI  = 4'd7;
    localparam logic [3:0] MFLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_en = 1'b0;
    logic [3:0]  in_op = 4'd0;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        out_busy;
    logic [31:0] out_rdata;
    logic [31:0] out_hi;
    logic [31:0] out_lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
        string       name;
    } opExp_t;

    typedef struct {
        logic [31:0] data;
        string       name;
    } rdExp_t;

    opExp_t      expOp[$];
    rdExp_t      expRd[$];
    int          checks = 0;
    int          passes = 0;
    logic        rdStrobe = 1'b0;
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_busy  (out_busy),
        .out_rdata (out_rdata),
        .out_hi    (out_hi),
        .out_lo    (out_lo)
    );

    always #5 clk = ~clk;

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endfunction

    function automatic void failNow(string name);
        checks++;
        $display("[TB] FAIL %s: expected event did not occur", name);
    endfunction

    // Reference: plain 64-bit integer arithmetic straight from the op definitions.
    function automatic void refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] hi, input logic [31:0] lo,
                                     output logic [31:0] nh, output logic [31:0] nl);
        longint          ps;
        longint unsigned pu;
        longint          q;
        longint          r;
        nh = hi;
        nl = lo;
        case (op)
            MULT: begin
                ps = longint'(int'(a)) * longint'(int'(b));
                nh = ps[63:32];
                nl = ps[31:0];
            end
            MULTU: begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                nh = pu[63:32];
                nl = pu[31:0];
            end
            DIV: if (b != 0) begin
                q = longint'(int'(a)) / longint'(int'(b));
                r = longint'(int'(a)) % longint'(int'(b));
                nh = r[31:0];
                nl = q[31:0];
            end
            DIVU: if (b != 0) begin
                nh = a % b;
                nl = a / b;
            end
            MTHI: nh = a;
            MTLO: nl = a;
            default: ;
        endcase
    endfunction

    function automatic int latencyOf(logic [3:0] op);
        return (op == MULT || op == MULTU) ? MC : DC;
    endfunction

    int   busyCnt = 0;
    logic prevBusy = 1'b0;

    always @(negedge clk) begin
        opExp_t e;
        rdExp_t r;
        if (reset) begin
            busyCnt  = 0;
            prevBusy = 1'b0;
        end else begin
            if (rdStrobe) begin
                if (expRd.size() == 0) failNow("unexpected read strobe");
                else begin
                    r = expRd.pop_front();
                    checkOutput(r.name, out_rdata, r.data);
                end
            end
            if (out_busy) begin
                busyCnt++;
            end else if (prevBusy) begin
                if (expOp.size() == 0) failNow("unexpected busy completion");
                else begin
                    e = expOp.pop_front();
                    checkOutput({e.name, " HI"}, out_hi, e.hi);
                    checkOutput({e.name, " LO"}, out_lo, e.lo);
                    checkOutput({e.name, " busy cycles"}, 32'(busyCnt), 32'(e.cycles));
                end
                busyCnt = 0;
            end
            prevBusy = out_busy;
        end
    end

    task automatic waitIdle();
        int n = 0;
        while (out_busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_busy) failNow("wait for idle timed out");
    endtask

    task automatic readRd(input logic [3:0] op, input string name);
        rdExp_t r;
        r.data = (op == MFHI) ? mHi : mLo;
        r.name = name;
        expRd.push_back(r);
        in_en    = 1'b1;
        in_op    = op;
        rdStrobe = 1'b1;
        @(posedge clk); #1;
        rdStrobe = 1'b0;
        in_en    = 1'b0;
        in_op    = NONE;
    endtask

    // junkOp: 0 = bus idle while busy, 15 = random ops, otherwise that op held.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] junkOp, input bit rdOld, input string name);
        logic [31:0] nh;
        logic [31:0] nl;
        opExp_t      e;
        rdExp_t      r;
        bit          isStart;
        int          cyc;
        waitIdle();
        refModel(op, a, b, mHi, mLo, nh, nl);
        isStart = (op >= MULT && op <= DIVU);
        cyc = latencyOf(op);
        if (isStart) begin
            e.hi = nh; e.lo = nl; e.cycles = cyc; e.name = name;
            expOp.push_back(e);
        end
        in_en = 1'b1; in_op = op; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_en = 1'b0; in_op = NONE;
        if (isStart) begin
            for (int k = 1; k <= cyc; k++) begin
                if (k == 1 && rdOld) begin
                    in_en = 1'b1;
                    in_op = ($urandom_range(0, 1) == 0) ? MFHI : MFLO;
                    r.data = (in_op == MFHI) ? mHi : mLo;
                    r.name = {name, " old value during busy"};
                    expRd.push_back(r);
                    rdStrobe = 1'b1;
                end else if (junkOp == 4'd15) begin
                    in_en = 1'b1;
                    in_op = 4'($urandom_range(1, 8));
                    in_a  = $urandom;
                    in_b  = $urandom;
                end else if (junkOp != 4'd0) begin
                    in_en = 1'b1;
                    in_op = junkOp;
                    in_a  = $urandom;
                end
                @(posedge clk); #1;
                rdStrobe = 1'b0;
            end
            in_en = 1'b0; in_op = NONE;
        end
        mHi = nh;
        mLo = nl;
    endtask

    // Second op held from the first op's accept onward; it must start only after busy drops.
    task automatic backToBack(input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                              input logic [3:0] op2, input logic [31:0] a2, input logic [31:0] b2);
        logic [31:0] nh;
        logic [31:0] nl;
        opExp_t      e;
        int          n = 0;
        waitIdle();
        refModel(op1, a1, b1, mHi, mLo, nh, nl);
        e.hi = nh; e.lo = nl; e.cycles = latencyOf(op1); e.name = "back-to-back first";
        expOp.push_back(e);
        mHi = nh; mLo = nl;
        in_en = 1'b1; in_op = op1; in_a = a1; in_b = b1;
        @(posedge clk); #1;
        refModel(op2, a2, b2, mHi, mLo, nh, nl);
        e.hi = nh; e.lo = nl; e.cycles = latencyOf(op2); e.name = "back-to-back second";
        expOp.push_back(e);
        in_op = op2; in_a = a2; in_b = b2;
        while (out_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_en = 1'b0; in_op = NONE;
        mHi = nh; mLo = nl;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;

        #2 reset = 1'b1;
        #1;
        checkOutput("reset busy", 32'(out_busy), 32'd0);
        checkOutput("reset HI", out_hi, 32'd0);
        checkOutput("reset LO", out_lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        applyStimulus(MULT,  32'hFFFFFFFE, 32'd3, 4'd0, 1'b1, "MULT -2*3");
        applyStimulus(MULTU, 32'hFFFFFFFF, 32'd2, 4'd0, 1'b1, "MULTU max*2");
        applyStimulus(DIV,   32'hFFFFFFF9, 32'd2, 4'd0, 1'b0, "DIV -7/2");
        applyStimulus(DIVU,  32'd7,        32'd0, 4'd0, 1'b0, "DIVU 7/0");
        applyStimulus(MTHI,  32'h12345678, 32'd0, 4'd0, 1'b0, "MTHI");
        readRd(MFHI, "MFHI after MTHI");
        applyStimulus(DIV,   32'h80000000, 32'hFFFFFFFF, MTLO, 1'b0, "DIV overflow with MTLO while busy");
        applyStimulus(MTLO,  32'hCAFEBABE, 32'd0, 4'd0, 1'b0, "MTLO");
        readRd(MFLO, "MFLO after MTLO");
        readRd(NONE, "rdata shows LO for NONE");
        readRd(4'd12, "rdata shows LO for op 12");
        readRd(MFHI, "MFHI steady");
        applyStimulus(DIVU,  32'h12345678, 32'd0, MTHI, 1'b1, "DIVU by zero with MTHI while busy");
        backToBack(MULT, 32'h7FFFFFFF, 32'h80000000, DIV, 32'd100, 32'hFFFFFFFD);

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(1, 6));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: a = 32'h80000000;
                3: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            applyStimulus(op, a, b, 4'd15, 1'($urandom_range(0, 1)), $sformatf("random op%0d #%0d", op, i));
            if ($urandom_range(0, 2) == 0) readRd(($urandom_range(0, 1) == 0) ? MFHI : MFLO, "random read");
        end

        applyStimulus(MTHI, 32'hA5A5A5A5, 32'd0, 4'd0, 1'b0, "MTHI before reset");
        applyStimulus(MTLO, 32'h5A5A5A5A, 32'd0, 4'd0, 1'b0, "MTLO before reset");
        in_en = 1'b1; in_op = DIV; in_a = 32'd1000; in_b = 32'd3;
        @(posedge clk); #1;
        in_en = 1'b0; in_op = NONE;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checkOutput("mid-op reset busy", 32'(out_busy), 32'd0);
        checkOutput("mid-op reset HI", out_hi, 32'd0);
        checkOutput("mid-op reset LO", out_lo, 32'd0);
        #4 reset = 1'b0;
        mHi = 32'd0;
        mLo = 32'd0;
        repeat (15) @(posedge clk);
        #1;
        checkOutput("no commit after reset HI", out_hi, 32'd0);
        checkOutput("no commit after reset LO", out_lo, 32'd0);
        checkOutput("no busy after reset", 32'(out_busy), 32'd0);

        applyStimulus(MULTU, 32'd3, 32'd4, 4'd0, 1'b1, "MULTU after reset");
        waitIdle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("op queue drained", 32'(expOp.size()), 32'd0);
        checkOutput("read queue drained", 32'(expRd.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
